// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, single-outstanding imem fetch, stall skid, redirect flush
// Optional IF_MISALIGN_TRAP_EN adds misalign_trap and a TRAP state for unaligned redirect targets.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
`ifdef IF_MISALIGN_TRAP_EN
  output logic        misalign_trap,
`endif
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH, S_TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic        outstanding;
  logic        consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      skid_data_q  <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    outstanding  = (state_q == S_REQ) || (state_q == S_FLUSH);
    consume      = inst_valid_q && !stall;

    if (redirect_en) begin
      pc_d         = redirect_pc & 32'hFFFF_FFFC;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      skid_valid_d = 1'b0;
      // A response still in flight belongs to the old path and must be swallowed.
      state_d      = (outstanding && !imem_rvalid) ? S_FLUSH : S_REQ;
`ifdef IF_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d    = redirect_pc;
        state_d = S_TRAP;
      end
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_rvalid) begin
            pc_d = pc_q + 32'd4;
            if (inst_valid_q && stall) begin
              skid_data_d  = imem_rdata;
              skid_pc_d    = pc_q;
              skid_valid_d = 1'b1;
              state_d      = S_HOLD;
            end else begin
              inst_d       = imem_rdata;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
            end
          end else if (consume) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
          end
        end
        S_HOLD: begin
          if (!stall || !skid_valid_q) state_d = S_REQ;
          if (!stall && skid_valid_q) begin
            inst_d       = skid_data_q;
            inst_pc_d    = skid_pc_q;
            inst_valid_d = 1'b1;
            skid_valid_d = 1'b0;
          end else if (consume) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
          end
        end
        S_FLUSH: if (imem_rvalid) state_d = S_REQ;
`ifdef IF_MISALIGN_TRAP_EN
        S_TRAP: state_d = S_TRAP;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = (state_q == S_REQ);
`ifdef IF_MISALIGN_TRAP_EN
    misalign_trap = (state_q == S_TRAP);
`endif
  end

  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized bench for if_fetch against a stream-level reference model
// Honours IF_MISALIGN_TRAP_EN when the design is built with it.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  if_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents: a few directed images, otherwise a scrambled function of the address.
  int mode = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mode == 1 && a == 32'h0) return 32'hF000_0067;
    if (mode == 2 && a == 32'h0) return 32'h0000_0043;
    if (mode == 2 && a == 32'h4) return 32'h0000_0003;
    if (mode == 2 && a == 32'h8) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          fixed_lat = 1;

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit r);
    @(posedge clk);
    #1;
    rst         = r;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (r) mem_pend = 1'b0;
    else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 1'b0;
      end
    end else if (imem_req) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    end
    stall       = st;
    redirect_en = rd;
    redirect_pc = rpc;
  endtask

  // Reference model: expected fetch address, queue of accepted-but-not-yet-shown words.
  logic [63:0] m_q[$];
  logic [63:0] m_e;
  logic [31:0] m_exp_pc = 32'h0, m_req_addr = 32'h0;
  bit          m_out = 0, m_drop = 0, m_must = 0;
  int          m_idle = 0;
  bit          p_rst = 1, p_valid = 0, p_stall = 0, p_req = 0, p_rvalid = 0, p_redir = 0;
  logic [31:0] p_inst = 32'h0, p_inst_pc = 32'h0, p_addr = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, NOP);
        chk("rst_inst_pc", inst_pc, 32'h0);
        m_q.delete();
        m_exp_pc = 32'h0;
        m_out = 0; m_drop = 0; m_must = 0; m_idle = 0;
        p_rst = 1;
      end else begin
        if (!inst_valid) chk("nop_fill", inst, NOP);
        if (!p_rst) begin
          if (p_redir) chk("redirect_kill", {31'b0, inst_valid}, 32'h0);
          else if (p_valid && p_stall) begin
            chk("hold_valid", {31'b0, inst_valid}, 32'h1);
            chk("hold_inst", inst, p_inst);
            chk("hold_pc", inst_pc, p_inst_pc);
          end else if (inst_valid) begin
            if (m_q.size() == 0) chk("spurious_inst", {31'b0, inst_valid}, 32'h0);
            else begin
              m_e = m_q.pop_front();
              chk("stream_pc", inst_pc, m_e[63:32]);
              chk("stream_inst", inst, m_e[31:0]);
            end
          end else if (m_must) chk("fetch_latency", {31'b0, inst_valid}, 32'h1);
          if (p_req && !p_rvalid && !p_redir) begin
            chk("req_held", {31'b0, imem_req}, 32'h1);
            if (imem_req) chk("addr_stable", imem_addr, p_addr);
          end
        end
        if (imem_rvalid) begin
          if (!m_drop && !redirect_en) begin
            m_q.push_back({m_req_addr, imem_rdata});
            m_exp_pc = m_req_addr + 32'd4;
          end
          m_out = 0; m_drop = 0; m_idle = 0;
        end
        if (imem_req && !(p_req && !p_rvalid)) begin
          chk("one_outstanding", {31'b0, m_out}, 32'h0);
          chk("fetch_addr", imem_addr, m_exp_pc);
          m_out = 1; m_req_addr = imem_addr; m_idle = 0;
        end
        if (redirect_en) begin
          m_q.delete();
          m_exp_pc = redirect_pc & 32'hFFFF_FFFC;
          if (m_out && !imem_rvalid) m_drop = 1;
        end
        m_must = !redirect_en && (m_q.size() != 0) && (!inst_valid || !stall);
        m_idle++;
        if (m_idle > 40) begin
          chk("progress_idle_cycles", m_idle, 32'h0);
          m_idle = 0;
        end
        p_rst = 0;
      end
      p_valid = inst_valid; p_stall = stall; p_req = imem_req; p_rvalid = imem_rvalid;
      p_redir = redirect_en; p_inst = inst; p_inst_pc = inst_pc; p_addr = imem_addr;
    end
  end

  task automatic do_reset(input int m);
    mode = m;
    fixed_lat = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  logic [31:0] rpc;
  bit          st, rd;

  initial begin
    // Reset release, first fetch with 1-cycle memory.
    do_reset(1);
    chk("A_idle_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 0);
    chk("A_req", {31'b0, imem_req}, 32'h1);
    chk("A_addr0", imem_addr, 32'h0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("A_inst", inst, 32'hF000_0067);
    chk("A_inst_pc", inst_pc, 32'h0);
    chk("A_valid", {31'b0, inst_valid}, 32'h1);
    chk("A_next_addr", imem_addr, 32'h4);

    // Back-to-back stream.
    do_reset(2);
    repeat (3) step(0, 0, 0, 0);
    chk("B_inst0", inst, 32'h43);
    chk("B_pc0", inst_pc, 32'h0);
    repeat (2) step(0, 0, 0, 0);
    chk("B_inst1", inst, 32'h03);
    chk("B_pc1", inst_pc, 32'h4);
    repeat (2) step(0, 0, 0, 0);
    chk("B_inst2", inst, 32'h13);
    chk("B_pc2", inst_pc, 32'h8);

    // Stall for 4 cycles while the next response lands in the skid.
    do_reset(2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("C_inst_s0", inst, 32'h43);
    for (int k = 1; k < 4; k++) begin
      step(1, 0, 0, 0);
      chk("C_inst_held", inst, 32'h43);
      chk("C_valid_held", {31'b0, inst_valid}, 32'h1);
    end
    step(0, 0, 0, 0);
    chk("C_inst_last", inst, 32'h43);
    chk("C_hold_req", {31'b0, imem_req}, 32'h0);
    fixed_lat = 3;
    step(0, 0, 0, 0);
    chk("C_skid_inst", inst, 32'h03);
    chk("C_skid_pc", inst_pc, 32'h4);
    chk("C_addr8", imem_addr, 32'h8);

    // Redirect with the 0x8 fetch outstanding, then with rvalid in the same cycle.
    step(0, 1, 32'h100, 0);
    fixed_lat = 1;
    step(0, 0, 0, 0);
    chk("D_flush_req", {31'b0, imem_req}, 32'h0);
    chk("D_flush_valid", {31'b0, inst_valid}, 32'h0);
    step(0, 0, 0, 0);
    chk("D_flush_req2", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 0);
    chk("D_req_100", imem_addr, 32'h100);
    chk("D_req_on", {31'b0, imem_req}, 32'h1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("D_inst_pc_100", inst_pc, 32'h100);
    chk("D_inst_100", inst, mem_word(32'h100));
    step(0, 1, 32'h200, 0);
    step(0, 1, 32'hFFFF_FFFC, 0);
    chk("D_noflush_addr", imem_addr, 32'h200);
    chk("D_noflush_req", {31'b0, imem_req}, 32'h1);

    // Wrap of the fetch address.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("E_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 1, 32'h102, 0);
    chk("E_addr_wrap", imem_addr, 32'h0);
    chk("E_pc_top", inst_pc, 32'hFFFF_FFFC);

    // Misaligned redirect.
    step(0, 0, 0, 0);
    chk("F_flush_req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("F_trap_req", {31'b0, imem_req}, 32'h0);
    chk("F_trap", {31'b0, misalign_trap}, 32'h1);
    step(0, 1, 32'h200, 0);
    chk("F_trap_hold", {31'b0, misalign_trap}, 32'h1);
    step(0, 0, 0, 0);
    chk("F_trap_clear", {31'b0, misalign_trap}, 32'h0);
    chk("F_addr_200", imem_addr, 32'h200);
`else
    chk("F_masked_addr", imem_addr, 32'h100);
    chk("F_masked_req", {31'b0, imem_req}, 32'h1);
`endif

    // Randomized traffic with random latency, stalls, redirects and one reset pulse.
    mode = 0;
    fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom % 100) < 35;
      rd = ($urandom % 100) < 4;
      if ($urandom % 8 == 0) rpc = 32'hFFFF_FFF0 | ($urandom % 16);
      else rpc = $urandom & 32'h0000_FFFF;
`ifdef IF_MISALIGN_TRAP_EN
      rpc = rpc & 32'hFFFF_FFFC;
`endif
      step(st, rd, rpc, (i >= 1500 && i < 1502));
    end
    repeat (5) step(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage for the single-cycle core; sits directly upstream of the immediate sign/zero-extend unit and decoder.
- Holds the PC and issues one-outstanding-request fetches to instruction memory.
- Registers the returned word as `inst` with its `inst_pc` and a valid flag; `inst` feeds the extend unit's `inst` input.
- Handles consumer stall and branch/jump redirect, including discard of an in-flight stale response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on `inst` while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until `imem_rvalid`.
- imem_addr  out  32  fetch address; stable while `imem_req`=1.
- imem_rvalid  in  1  response strobe, exactly one per request; earliest is the cycle after the request is raised.
- imem_rdata  in  32  instruction word, valid with `imem_rvalid`.
- stall  in  1  downstream cannot accept; current `inst` must be held.
- redirect_en  in  1  one-cycle pulse: load new PC (taken branch/jump).
- redirect_pc  in  32  redirect target.
- inst  out  32  fetched instruction to extend/decode.
- inst_pc  out  32  address of `inst`.
- inst_valid  out  1  `inst` is valid; consumed on a cycle with `inst_valid`=1 and `stall`=0.

Behaviour:
- Reset (async, any state, including mid-request):
  - pc=RESET_PC, state=IDLE, imem_req=0, inst=NOP_INST, inst_pc=0, inst_valid=0.
  - A response arriving after reset deasserts is ignored only if in FLUSH; the memory side is also reset, so no stale response is expected.
- State IDLE:
  - Lasts one cycle after reset release.
  - Next cycle goes to REQ with imem_req=1, imem_addr=pc.
- State REQ: imem_req=1, imem_addr=pc. On imem_rvalid:
  - inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
  - If the currently held instruction is not being consumed this cycle (inst_valid=1 and stall=1), the response must not overwrite it. Instead go to HOLD with the response buffered in a one-entry skid register.
  - Otherwise stay in REQ and issue the next fetch on the following cycle.
  - Fetch latency: rdata appears on `inst` the cycle after `imem_rvalid`.
- State HOLD: imem_req=0; `inst`, `inst_pc`, `inst_valid` frozen.
  - When stall=0: `inst` is consumed, the skid entry moves to `inst`, and the state returns to REQ next cycle.
  - If the skid is empty, return to REQ.
- Consumption: on inst_valid=1, stall=0 with no new response, inst_valid<=0 and inst<=NOP_INST.
- Redirect (redirect_en=1), priority over all other events except reset:
  - pc<=redirect_pc, inst_valid<=0, inst<=NOP_INST, skid cleared.
  - If a request is outstanding and imem_rvalid=0 this cycle, go to FLUSH. In FLUSH, imem_req=0, wait for imem_rvalid, discard the data, then go to REQ.
  - If imem_rvalid=1 in the same cycle, discard that data and go directly to REQ.
  - Redirect while in FLUSH updates pc again and stays in FLUSH.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect with redirect_pc[1:0]≠0 behaves as described under Optional Feature.
- No combinational path from any input to imem_req/imem_addr except via registers.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port `misalign_trap` (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]≠0 enters state TRAP: no fetches, inst_valid=0, misalign_trap=1, pc=redirect_pc unchanged.
  - TRAP is left only by an aligned redirect, which clears misalign_trap and proceeds as a normal redirect.
- Not defined:
  - No port.
  - redirect_pc[1:0] are forced to 2'b00 before loading pc.

Test Plan:
- Reset sequence: rst=1 then 0, memory returns 32'hF000_0067 at 0x0 with 1-cycle latency → imem_addr=0x0, then inst=32'hF000_0067, inst_pc=0x0, inst_valid=1; next imem_addr=0x4.
- Back-to-back fetch: memory returns 0x43, 0x03, 0x13 at 0x0/0x4/0x8 with stall=0 → three consecutive valid instructions with inst_pc 0x0, 0x4, 0x8; no NOP bubbles beyond memory latency.
- Stall: stall=1 for 4 cycles while inst=0x43 valid and next response 0x03 arrives → inst stays 0x43 for 4 cycles; 0x03 appears the cycle after stall drops; nothing lost or duplicated.
- Redirect with outstanding request: redirect_en to 0x100 while fetch of 0x8 is pending (rvalid 3 cycles later) → response for 0x8 discarded, next imem_addr=0x100, inst_valid=0 until the 0x100 data arrives. Repeat with rvalid in the same cycle as redirect_en → no FLUSH cycle.
- Wrap: redirect to 0xFFFF_FFFC → following fetch address is 0x0000_0000.
- Misalignment: redirect to 0x102. With IF_MISALIGN_TRAP_EN, misalign_trap=1 and imem_req=0 until a redirect to 0x200. Without it, next imem_addr=0x100.
